// File: rtl/pvt_host_cmd_master.sv
// Host-side command master for the PVT sensor UART protocol: serializes header and
// payload bytes to a byte-level UART transmitter and collects READ_DATA responses.
module pvt_host_cmd_master #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_group,
  input  logic [4:0]  cmd_code,
  input  logic [31:0] cmd_data,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  output logic [7:0]  tx_byte,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a byte or command moves on a cycle where valid and ready are both
  // high; once valid is raised it stays high with stable data until that cycle.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_RSP_HI  = 3'd3,
    S_RSP_LO  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [4:0] CODE_READ_DATA = 5'd10;

  state_t      state_q, state_d;
  logic [2:0]  group_q, group_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        tmo_hit;
  logic [7:0]  pay_byte;

  function automatic logic [2:0] n_bytes(input logic [4:0] code);
    case (code)
      5'd0, 5'd1, 5'd5, 5'd7, 5'd8: n_bytes = 3'd1;
      5'd2, 5'd3, 5'd4:             n_bytes = 3'd4;
      5'd6, 5'd9:                   n_bytes = 3'd2;
      default:                      n_bytes = 3'd0;
    endcase
  endfunction

  assign tmo_hit = (tmo_q == (TIMEOUT_CYCLES - 24'd1));

  // Payload goes out most significant byte first; cnt_q counts bytes still to send.
  always_comb begin
    case (cnt_q)
      3'd4:    pay_byte = data_q[31:24];
      3'd3:    pay_byte = data_q[23:16];
      3'd2:    pay_byte = data_q[15:8];
      default: pay_byte = data_q[7:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    group_d       = group_q;
    code_d        = code_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    hi_d          = hi_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    tx_byte_valid = 1'b0;
    tx_byte       = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          group_d = cmd_group;
          code_d  = cmd_code;
          data_d  = cmd_data;
          cnt_d   = n_bytes(cmd_code);
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        tx_byte_valid = 1'b1;
        tx_byte       = {group_q, code_q};
        if (tx_byte_ready) begin
          if (cnt_q != 3'd0) begin
            state_d = S_PAYLOAD;
          end else if (code_q == CODE_READ_DATA) begin
            tmo_d   = 24'd0;
            state_d = S_RSP_HI;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PAYLOAD: begin
        tx_byte_valid = 1'b1;
        tx_byte       = pay_byte;
        if (tx_byte_ready) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_DONE;
        end
      end
      S_RSP_HI: begin
        // A byte arriving on the terminal-count cycle takes priority over the timeout.
        if (rx_byte_valid) begin
          hi_d    = rx_byte;
          tmo_d   = 24'd0;
          state_d = S_RSP_LO;
        end else if (tmo_hit) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_RSP_LO: begin
        if (rx_byte_valid) begin
          rsp_data_d  = {hi_q, rx_byte};
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (tmo_hit) begin
          rsp_timeout_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      group_q       <= 3'd0;
      code_q        <= 5'd0;
      data_q        <= 32'd0;
      cnt_q         <= 3'd0;
      tmo_q         <= 24'd0;
      hi_q          <= 8'd0;
      rsp_data_q    <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      group_q       <= group_d;
      code_q        <= code_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      hi_q          <= hi_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_data    = rsp_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pvt_host_cmd_master.sv
// Bench for pvt_host_cmd_master: directed cases plus randomized commands, checked
// against a byte-list / response-timing model of the command protocol.
module tb_pvt_host_cmd_master;

  localparam int T = 64;
  localparam logic [23:0] TO = 24'd64;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_group;
  logic [4:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        tx_byte_valid;
  logic        tx_byte_ready;
  logic [7:0]  tx_byte;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;
  logic [2:0]  dbg_state;

  pvt_host_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_group     (cmd_group),
    .cmd_code      (cmd_code),
    .cmd_data      (cmd_data),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready),
    .tx_byte       (tx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    bit          to;
    logic [15:0] data;
  } rsp_exp_t;

  logic [7:0]  exp_q[$];
  rsp_exp_t    exp_rsp[$];
  logic [15:0] model_rsp_data = 16'd0;
  int          hs_log[$];
  int          ready_mode = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int n_of(input logic [4:0] code);
    case (code)
      5'd0, 5'd1, 5'd5, 5'd7, 5'd8: return 1;
      5'd2, 5'd3, 5'd4:             return 4;
      5'd6, 5'd9:                   return 2;
      default:                      return 0;
    endcase
  endfunction

  // ---------------- tx ready driver ----------------
  initial begin
    tx_byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_byte_ready = 1'b1;
        1:       tx_byte_ready = ~tx_byte_ready;
        2:       tx_byte_ready = 1'($urandom_range(0, 1));
        default: tx_byte_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit         prev_stall;
    logic [7:0] prev_byte;
    int         qs;
    bit         e_v, e_t;
    logic [15:0] e_d;
    prev_stall = 1'b0;
    prev_byte  = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", tx_byte_valid, 1);
          check("hold_byte", tx_byte, prev_byte);
        end
        if (tx_byte_valid && tx_byte_ready) begin
          hs_log.push_back(cyc);
          qs = exp_q.size();
          check("tx_expected_pending", (qs > 0), 1);
          if (qs > 0) check("tx_byte", tx_byte, exp_q.pop_front());
        end
        prev_stall = tx_byte_valid && !tx_byte_ready;
        prev_byte  = tx_byte;

        e_v = 1'b0;
        e_t = 1'b0;
        e_d = 16'd0;
        if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
          e_v = !exp_rsp[0].to;
          e_t = exp_rsp[0].to;
          e_d = exp_rsp[0].data;
          void'(exp_rsp.pop_front());
        end
        if (rsp_valid || rsp_timeout || e_v || e_t) begin
          check("rsp_valid", rsp_valid, e_v);
          check("rsp_timeout", rsp_timeout, e_t);
          check("rsp_data", rsp_data, e_d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] g, input logic [4:0] c, input logic [31:0] d);
    bit acc;
    int n;
    logic [31:0] tmp;
    acc       = 1'b0;
    cmd_valid = 1'b1;
    cmd_group = g;
    cmd_code  = c;
    cmd_data  = d;
    for (int i = 0; i < 2000 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({g, c});
        n = n_of(c);
        for (int b = n - 1; b >= 0; b--) begin
          tmp = d >> (8 * b);
          exp_q.push_back(tmp[7:0]);
        end
        acc = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    check("cmd_accept", acc, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (!busy && exp_q.size() == 0 && exp_rsp.size() == 0) ok = 1'b1;
    end
    check("idle_reached", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    @(posedge clk);
    #1;
    rx_byte_valid = 1'b0;
  endtask

  // READ_DATA: d1/d2 are the wait-cycle index (counter value) at which each rx byte arrives.
  task automatic do_read(input logic [2:0] g, input int d1, input int d2,
                         input logic [7:0] hi, input logic [7:0] lo);
    bit seen;
    int k;
    rsp_exp_t e;
    send_cmd(g, 5'd10, 32'd0);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (tx_byte_valid && tx_byte_ready) seen = 1'b1;
    end
    check("hdr_seen", seen, 1);
    if (!seen) return;
    k = cyc + 1;
    if (d1 > T - 1) begin
      e.cyc = k + T; e.to = 1'b1; e.data = model_rsp_data;
    end else if (d2 > T - 1) begin
      e.cyc = k + d1 + 1 + T; e.to = 1'b1; e.data = model_rsp_data;
    end else begin
      model_rsp_data = {hi, lo};
      e.cyc = k + d1 + 1 + d2 + 1; e.to = 1'b0; e.data = model_rsp_data;
    end
    exp_rsp.push_back(e);
    @(posedge clk);
    repeat (d1) @(posedge clk);
    #1;
    pulse_rx(hi);
    repeat (d2) @(posedge clk);
    #1;
    pulse_rx(lo);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, d1, d2;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_group     = 3'd0;
    cmd_code      = 5'd0;
    cmd_data      = 32'd0;
    rx_byte_valid = 1'b0;
    rx_byte       = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_tx_valid", tx_byte_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // EN write, ready always high: back-to-back bytes, busy drops 2 cycles after last byte
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    hs_log.delete();
    send_cmd(3'd2, 5'd0, 32'h1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && hs_log.size() < 2; i++) tick();
    check("en_two_bytes", hs_log.size(), 2);
    if (hs_log.size() >= 2) begin
      check("en_consecutive", hs_log[1] - hs_log[0], 1);
      for (int i = 0; i < 20 && busy; i++) tick();
      check("en_busy_low_cycle", cyc, hs_log[1] + 2);
    end
    wait_idle();

    // COEF_C0 with ready toggling
    ready_mode = 1;
    send_cmd(3'd0, 5'd2, 32'hDEADBEEF);
    cmd_valid = 1'b0;
    wait_idle();

    // READ_DATA with slow response, then timeouts and terminal-count boundaries
    ready_mode = 0;
    do_read(3'd1, 50, 3, 8'h12, 8'h34);
    do_read(3'd1, T + 5, 0, 8'hEE, 8'hEE);
    do_read(3'd3, T - 1, T - 1, 8'hA5, 8'h5A);
    do_read(3'd2, 0, T, 8'h11, 8'h22);
    do_read(3'd7, T, 0, 8'h33, 8'h44);

    // Reset in PAYLOAD of COEF_A, then OFFSET write
    ready_mode = 0;
    hs_log.delete();
    send_cmd(3'd5, 5'd4, 32'h01020304);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && hs_log.size() < 2; i++) tick();
    check("coefa_progress", hs_log.size(), 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_rsp.delete();
    model_rsp_data = 16'd0;
    #1;
    check("mid_rst_tx_valid", tx_byte_valid, 0);
    check("mid_rst_tx_byte", tx_byte, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_timeout", rsp_timeout, 0);
    check("mid_rst_rsp_data", rsp_data, model_rsp_data);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_cmd(3'd0, 5'd6, 32'h3FF);
    cmd_valid = 1'b0;
    wait_idle();

    // Back-to-back with cmd_valid held; stray rx during a stalled HDR
    ready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send_cmd(3'd4, 5'd1, 32'h55);
    pulse_rx(8'h99);
    pulse_rx(8'h98);
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, 31);
      if (c == 10) c = 11;
      send_cmd(3'($urandom_range(0, 7)), 5'(c), $urandom);
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Randomized mix
    for (int i = 0; i < 25; i++) begin
      ready_mode = $urandom_range(0, 2);
      c = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) c = 10;
      if (c == 10) begin
        d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 10);
        d2 = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 10);
        do_read(3'($urandom_range(0, 7)), d1, d2, 8'($urandom), 8'($urandom));
      end else begin
        send_cmd(3'($urandom_range(0, 7)), 5'(c), $urandom);
        cmd_valid = 1'b0;
        wait_idle();
      end
    end

    check("tx_queue_drained", exp_q.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pvt_host_cmd_master.md
Name: pvt_host_cmd_master

Overview:
Host-side initiator for the PVT sensor UART command protocol. It accepts one command per handshake, serializes the header byte and payload bytes into a byte-level UART transmitter, and for READ_DATA commands collects the two-byte sensor response from a byte-level UART receiver. It sits between a test or management controller and the uart_tx/uart_rx byte engines that drive the sensor wrappers.

Parameters:
TIMEOUT_CYCLES, 24'd1000000, cycles to wait for each response byte before aborting a READ_DATA command (minimum 1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command (high only in IDLE)
cmd_group  in  3  target sensor group number
cmd_code  in  5  register code: 0 EN, 1 I_BYPASS, 2 COEF_C0, 3 COEF_C1, 4 COEF_A, 5 CALIB, 6 OFFSET, 7 RST, 8 SEL, 9 COUNT, 10 READ_DATA
cmd_data  in  32  payload, right-aligned; only the low N bytes are sent
tx_byte_valid  out  1  byte available for uart_tx
tx_byte_ready  in  1  uart_tx accepts the byte this cycle
tx_byte  out  8  byte to send
rx_byte_valid  in  1  one-cycle strobe from uart_rx
rx_byte  in  8  received byte
rsp_valid  out  1  one-cycle pulse: rsp_data valid
rsp_data  out  16  sensor reading
rsp_timeout  out  1  one-cycle pulse: READ_DATA aborted
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; cmd_ready=1, tx_byte_valid=0, tx_byte=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0. All counters and latched fields are 0. Reset may be asserted in any state and takes effect immediately; a transfer in progress is dropped and no pulse is emitted.
- Payload byte count N per code: codes 0, 1, 5, 7, 8 -> 1; codes 2, 3, 4 -> 4; codes 6, 9 -> 2; code 10 -> 0; codes 11-31 -> 0, sent as a header-only command with no response wait.
- Header byte: {cmd_group, cmd_code}, with group in bits [7:5] and code in bits [4:0].
- Payload bytes are sent MSB first: byte index N-1 first, cmd_data[7:0] last.
- IDLE:
  - When cmd_valid and cmd_ready are both high, latch group, code, data and N, then go to HDR.
  - cmd_ready is low in every other state.
- HDR:
  - tx_byte_valid=1 and tx_byte=header, held stable until tx_byte_ready.
  - On acceptance: go to PAYLOAD if N>0; else to RSP_HI if code==10; else to DONE.
- PAYLOAD:
  - Present byte cnt-1, where cnt starts at N; decrement cnt on each acceptance.
  - On the last acceptance: go to DONE.
- tx_byte_valid must not drop and tx_byte must not change while valid is high and ready is low.
- Bytes are back-to-back: if ready stays high, consecutive bytes go out on consecutive cycles.
- RSP_HI: wait for rx_byte_valid, latch rsp_data[15:8], then go to RSP_LO.
- RSP_LO: wait for rx_byte_valid, latch rsp_data[7:0], pulse rsp_valid in the following cycle, then go to DONE.
- rx_byte_valid is ignored outside RSP_HI and RSP_LO.
- Timeout:
  - A counter clears on entry to RSP_HI and again on entry to RSP_LO.
  - It increments each cycle while waiting.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, pulse rsp_timeout and go to DONE; rsp_data keeps its previous value.
  - If a byte arrives on the same cycle as the terminal count, the byte wins.
- DONE: one cycle, then IDLE. Earliest next acceptance is the cycle after DONE.
- Latency:
  - Write command: 1+N accepted tx bytes plus 2 cycles (accept cycle and DONE).
  - READ_DATA: rsp_valid is asserted 1 cycle after the second rx_byte_valid.
- rsp_valid and rsp_timeout are never high together.

Test Plan:
- EN write, group=2, code=0, data=0x1, tx_byte_ready always 1 -> tx bytes 0x40, 0x01 on consecutive cycles; no rsp pulse; busy low 2 cycles after the last byte.
- COEF_C0 write, group=0, code=2, data=0xDEADBEEF, with ready toggling 1/0 -> tx sequence 0x02, 0xDE, 0xAD, 0xBE, 0xEF; each byte is held stable through ready=0 cycles.
- READ_DATA, group=1, code=10; rx bytes 0x12 then 0x34 after 50 cycles -> tx 0x2A only; rsp_valid single pulse with rsp_data=0x1234.
- READ_DATA with TIMEOUT_CYCLES=16 and no rx bytes -> exactly one rsp_timeout pulse 16 cycles after entering RSP_HI; rsp_valid never asserted; cmd_ready returns high.
- Reset asserted while in PAYLOAD of COEF_A -> next cycle all outputs at reset values; a new OFFSET write (code=6, data=0x3FF) sends 0x06, 0x03, 0xFF.
- cmd_valid held high continuously with back-to-back commands -> cmd_ready high only in IDLE; no command is lost or duplicated; stray rx_byte_valid during HDR is ignored.
